// File: rtl/mem_arbiter_if.sv
// Request/grant/response bundle for both requesters plus the shared memory port.
// The arbiter takes the slave view; the requesters and memory model take the master view.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  if_req;
  logic [ADDR_W-1:0]     if_addr;
  logic                  if_gnt;
  logic                  if_rvalid;
  logic [DATA_W-1:0]     if_rdata;
  logic                  d_req;
  logic                  d_we;
  logic [ADDR_W-1:0]     d_addr;
  logic [DATA_W-1:0]     d_wdata;
  logic [DATA_W/8-1:0]   d_be;
  logic                  d_gnt;
  logic                  d_rvalid;
  logic [DATA_W-1:0]     d_rdata;
  logic                  mem_en;
  logic                  mem_we;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W/8-1:0]   mem_be;
  logic [DATA_W-1:0]     mem_rdata;
  logic                  busy;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, mem_be, busy
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, mem_be, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between instruction fetch and load/store,
// one transaction at a time, data-first with a fetch starvation guard.
module mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus_io
);

  localparam int SW    = $clog2(STARVE_MAX + 1);
  localparam int LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int BE_W  = DATA_W / 8;

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP} state_t;

  state_t              state_q;
  logic                run_q;
  logic [SW-1:0]       starve_q;
  logic [SW-1:0]       starve_d;
  logic [LAT_W-1:0]    lat_q;
  logic                sel_d_q;
  logic                we_q;
  logic [DATA_W-1:0]   resp_q;
  logic                if_gnt_q, d_gnt_q, if_rv_q, d_rv_q;
  logic                mem_en_q, mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic [BE_W-1:0]     mem_be_q;
  logic                fetch_win;
  logic                any_req;

  always_comb begin
    any_req   = bus_io.if_req || bus_io.d_req;
    fetch_win = bus_io.if_req && (!bus_io.d_req || (starve_q == SW'(STARVE_MAX)));
    starve_d  = starve_q;
    if (!bus_io.if_req || fetch_win)
      starve_d = '0;
    else if (starve_q != SW'(STARVE_MAX))
      starve_d = starve_q + SW'(1);
  end

  // run_q holds off arbitration for the first edge after reset release.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      run_q       <= 1'b0;
      starve_q    <= '0;
      lat_q       <= '0;
      sel_d_q     <= 1'b0;
      we_q        <= 1'b0;
      resp_q      <= '0;
      if_gnt_q    <= 1'b0;
      d_gnt_q     <= 1'b0;
      if_rv_q     <= 1'b0;
      d_rv_q      <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
    end else begin
      run_q       <= 1'b1;
      if_gnt_q    <= 1'b0;
      d_gnt_q     <= 1'b0;
      if_rv_q     <= 1'b0;
      d_rv_q      <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      case (state_q)
        ST_IDLE, ST_RESP: begin
          if (run_q) starve_q <= starve_d;
          if (run_q && any_req) begin
            state_q  <= ST_ISSUE;
            sel_d_q  <= !fetch_win;
            we_q     <= !fetch_win && bus_io.d_we;
            mem_en_q <= 1'b1;
            if (fetch_win) begin
              if_gnt_q   <= 1'b1;
              mem_addr_q <= bus_io.if_addr;
              mem_be_q   <= '1;
            end else begin
              d_gnt_q     <= 1'b1;
              mem_we_q    <= bus_io.d_we;
              mem_addr_q  <= bus_io.d_addr;
              mem_wdata_q <= bus_io.d_wdata;
              mem_be_q    <= bus_io.d_be;
            end
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          state_q <= ST_WAIT;
          lat_q   <= LAT_W'(MEM_LAT - 1);
        end
        ST_WAIT: begin
          if (lat_q == '0) begin
            resp_q  <= we_q ? '0 : bus_io.mem_rdata;
            if_rv_q <= !sel_d_q;
            d_rv_q  <= sel_d_q;
            state_q <= ST_RESP;
          end else begin
            lat_q <= lat_q - LAT_W'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus_io.if_gnt    = if_gnt_q;
  assign bus_io.d_gnt     = d_gnt_q;
  assign bus_io.if_rvalid = if_rv_q;
  assign bus_io.d_rvalid  = d_rv_q;
  assign bus_io.if_rdata  = resp_q;
  assign bus_io.d_rdata   = resp_q;
  assign bus_io.mem_en    = mem_en_q;
  assign bus_io.mem_we    = mem_we_q;
  assign bus_io.mem_addr  = mem_addr_q;
  assign bus_io.mem_wdata = mem_wdata_q;
  assign bus_io.mem_be    = mem_be_q;
  assign bus_io.busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed cycle checks plus a grant/response scoreboard
// on a MEM_LAT=1 instance, and a latency check on a MEM_LAT=3 instance.
module tb_mem_arbiter;

  logic clk;
  logic rst;
  int   n_chk  = 0;
  int   n_fail = 0;

  typedef struct {
    logic        is_d;
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;

  txn_t gq[$];
  txn_t rq[$];
  txn_t ge, re;

  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus_a ();
  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus_b ();

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(4)) dut_a (
    .clk(clk), .rst(rst), .bus_io(bus_a));
  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3), .STARVE_MAX(4)) dut_b (
    .clk(clk), .rst(rst), .bus_io(bus_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return a ^ 32'hDEAD_BFEF;
  endfunction

  // Memory models: data is valid only in cycle E+MEM_LAT, garbage otherwise.
  logic        va = 1'b0;
  logic [31:0] aa = '0;
  logic [2:0]  vb = '0;
  logic [31:0] ab [3];
  always @(posedge clk) begin
    va    <= bus_a.mem_en;
    aa    <= bus_a.mem_addr;
    vb    <= {vb[1:0], bus_b.mem_en};
    ab[0] <= bus_b.mem_addr;
    ab[1] <= ab[0];
    ab[2] <= ab[1];
  end
  assign bus_a.mem_rdata = va    ? mem_f(aa)    : 32'hBAD0_BAD0;
  assign bus_b.mem_rdata = vb[2] ? mem_f(ab[2]) : 32'hBAD0_BAD0;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_txn(input logic is_d, input logic [31:0] addr, input logic [31:0] data,
                          input logic has_resp);
    txn_t t;
    t.is_d = is_d; t.addr = addr; t.data = data;
    gq.push_back(t);
    if (has_resp) rq.push_back(t);
  endtask

  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (bus_a.if_gnt || bus_a.d_gnt) begin
        check_val("one_gnt", 64'(bus_a.if_gnt & bus_a.d_gnt), 0);
        if (gq.size() == 0) check_val("gnt_unexpected", 1, 0);
        else begin
          ge = gq.pop_front();
          check_val("gnt_who", 64'(bus_a.d_gnt), 64'(ge.is_d));
          check_val("gnt_addr", 64'(bus_a.mem_addr), 64'(ge.addr));
          check_val("gnt_mem_en", 64'(bus_a.mem_en), 1);
        end
      end
      if (bus_a.if_rvalid || bus_a.d_rvalid) begin
        check_val("one_rvalid", 64'(bus_a.if_rvalid & bus_a.d_rvalid), 0);
        if (rq.size() == 0) check_val("rvalid_unexpected", 1, 0);
        else begin
          re = rq.pop_front();
          check_val("rv_who", 64'(bus_a.d_rvalid), 64'(re.is_d));
          check_val("rv_data", 64'(re.is_d ? bus_a.d_rdata : bus_a.if_rdata), 64'(re.data));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: timeout reached, expected end of test");
    $fatal(1);
  end

  initial begin
    int n_g;
    rst = 1'b0;
    bus_a.if_req = 0; bus_a.if_addr = '0; bus_a.d_req = 0; bus_a.d_we = 0;
    bus_a.d_addr = '0; bus_a.d_wdata = '0; bus_a.d_be = '0;
    bus_b.if_req = 0; bus_b.if_addr = '0; bus_b.d_req = 0; bus_b.d_we = 0;
    bus_b.d_addr = '0; bus_b.d_wdata = '0; bus_b.d_be = '0;
    tick(); tick();
    check_val("rst_ctrl", 64'({bus_a.if_gnt, bus_a.d_gnt, bus_a.if_rvalid, bus_a.d_rvalid,
                               bus_a.mem_en, bus_a.mem_we, bus_a.busy, bus_a.mem_be}), 0);
    check_val("rst_addr", 64'(bus_a.mem_addr), 0);
    check_val("rst_wdata", 64'(bus_a.mem_wdata), 0);
    check_val("rst_rdata", 64'({bus_a.if_rdata, bus_a.d_rdata}), 0);
    rst = 1'b1;
    tick(); tick();

    // Single fetch
    bus_a.if_req = 1; bus_a.if_addr = 32'h100;
    push_txn(0, 32'h100, 32'hDEAD_BEEF, 1);
    tick();
    check_val("f1_gnt", 64'({bus_a.if_gnt, bus_a.d_gnt, bus_a.mem_en}), 64'b101);
    check_val("f1_mem", 64'({bus_a.mem_we, bus_a.mem_be}), 64'h0F);
    check_val("f1_wdata", 64'(bus_a.mem_wdata), 0);
    check_val("f1_busy1", 64'(bus_a.busy), 1);
    bus_a.if_req = 0;
    tick();
    check_val("f1_c2", 64'({bus_a.busy, bus_a.mem_en, bus_a.if_rvalid}), 64'b100);
    tick();
    check_val("f1_c3", 64'({bus_a.busy, bus_a.if_rvalid}), 64'b11);
    check_val("f1_rdata", 64'(bus_a.if_rdata), 64'hDEAD_BEEF);
    tick();
    check_val("f1_c4", 64'({bus_a.busy, bus_a.if_rvalid}), 0);
    check_val("f1_hold", 64'(bus_a.if_rdata), 64'hDEAD_BEEF);

    // Simultaneous requests: data first, fetch issued from RESP
    bus_a.if_req = 1; bus_a.if_addr = 32'h300;
    bus_a.d_req = 1; bus_a.d_we = 0; bus_a.d_addr = 32'h200;
    push_txn(1, 32'h200, mem_f(32'h200), 1);
    push_txn(0, 32'h300, mem_f(32'h300), 1);
    tick();
    check_val("s_c1", 64'({bus_a.d_gnt, bus_a.if_gnt}), 64'b10);
    bus_a.d_req = 0;
    tick();
    tick();
    check_val("s_c3", 64'({bus_a.d_rvalid, bus_a.if_gnt}), 64'b10);
    tick();
    check_val("s_c4", 64'({bus_a.if_gnt, bus_a.d_rvalid}), 64'b10);
    bus_a.if_req = 0;
    tick();
    tick();
    check_val("s_c6", 64'(bus_a.if_rvalid), 1);
    tick();

    // Starvation guard: D,D,D,D,F repeated
    bus_a.if_req = 1; bus_a.if_addr = 32'h304;
    bus_a.d_req = 1; bus_a.d_addr = 32'h308;
    for (int k = 0; k < 10; k++) begin
      if (k % 5 == 4) push_txn(0, 32'h304, mem_f(32'h304), 1);
      else            push_txn(1, 32'h308, mem_f(32'h308), 1);
    end
    n_g = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (bus_a.if_gnt || bus_a.d_gnt) n_g++;
      if (n_g == 10) break;
    end
    bus_a.if_req = 0; bus_a.d_req = 0;
    check_val("starve_grants", 64'(n_g), 10);
    tick(); tick(); tick();

    // Reset during WAIT aborts the load; held request is granted after release
    bus_a.d_req = 1; bus_a.d_we = 0; bus_a.d_addr = 32'h80;
    push_txn(1, 32'h80, 0, 0);
    push_txn(1, 32'h80, mem_f(32'h80), 1);
    tick();
    check_val("r_c1", 64'(bus_a.d_gnt), 1);
    tick();
    rst = 1'b0;
    tick();
    check_val("r_c3_ctrl", 64'({bus_a.busy, bus_a.mem_en, bus_a.d_gnt, bus_a.d_rvalid,
                                bus_a.if_gnt, bus_a.if_rvalid}), 0);
    check_val("r_c3_rdata", 64'(bus_a.d_rdata), 0);
    tick();
    rst = 1'b1;
    check_val("r_c4", 64'({bus_a.busy, bus_a.d_gnt, bus_a.d_rvalid}), 0);
    tick();
    check_val("r_c5", 64'({bus_a.busy, bus_a.d_gnt, bus_a.d_rvalid}), 0);
    tick();
    check_val("r_c6", 64'(bus_a.d_gnt), 1);
    bus_a.d_req = 0;
    tick();
    tick();
    check_val("r_c8", 64'(bus_a.d_rvalid), 1);
    tick();

    // Store
    bus_a.d_req = 1; bus_a.d_we = 1; bus_a.d_addr = 32'h40;
    bus_a.d_wdata = 32'h1234_5678; bus_a.d_be = 4'b0011;
    push_txn(1, 32'h40, 0, 1);
    tick();
    check_val("st_c1", 64'({bus_a.d_gnt, bus_a.mem_en, bus_a.mem_we, bus_a.mem_be}), 64'h73);
    check_val("st_wdata", 64'(bus_a.mem_wdata), 64'h1234_5678);
    bus_a.d_req = 0; bus_a.d_we = 0;
    tick();
    check_val("st_c2", 64'({bus_a.mem_en, bus_a.mem_we, bus_a.if_gnt, bus_a.mem_wdata}), 0);
    tick();
    check_val("st_c3", 64'({bus_a.d_rvalid, bus_a.if_rvalid, bus_a.if_gnt}), 64'b100);
    check_val("st_rdata", 64'(bus_a.d_rdata), 0);
    tick();

    // MEM_LAT=3 load on the second instance
    bus_b.d_req = 1; bus_b.d_we = 0; bus_b.d_addr = 32'h500;
    tick();
    check_val("l3_gnt", 64'({bus_b.d_gnt, bus_b.mem_en}), 64'b11);
    bus_b.d_req = 0;
    for (int c = 2; c <= 4; c++) begin
      tick();
      check_val("l3_wait", 64'({bus_b.d_rvalid, bus_b.busy}), 64'b01);
    end
    tick();
    check_val("l3_rvalid", 64'(bus_b.d_rvalid), 1);
    check_val("l3_rdata", 64'(bus_b.d_rdata), 64'(mem_f(32'h500)));
    tick();

    check_val("gq_empty", 64'(gq.size()), 0);
    check_val("rq_empty", 64'(rq.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter that shares one single-port memory between the CPU's instruction-fetch path and its load/store path. The arbiter registers the winning request, drives the memory port for one cycle, waits a fixed memory latency, and returns the read data or write completion to the requester it granted. It is the first step from the single-cycle core toward a multicycle core with a unified memory. The core stalls on the handshake signals.

## Interface
- ADDR_W, 32, byte-address width
- DATA_W, 32, data width
- MEM_LAT, 1, cycles from mem_en to valid mem_rdata; legal range is 1 or more
- STARVE_MAX, 4, number of consecutive data grants while if_req is pending before fetch is forced to win; legal range is 1 or more

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-low reset
- if_req  in  1  fetch request; held high until if_gnt
- if_addr  in  ADDR_W  fetch address; stable while if_req=1 and no if_gnt
- if_gnt  out  1  one-cycle grant pulse
- if_rvalid  out  1  one-cycle response pulse
- if_rdata  out  DATA_W  fetch data; valid with if_rvalid
- d_req  in  1  data request; held high until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_be  in  DATA_W/8  store byte enables
- d_gnt  out  1  one-cycle grant pulse
- d_rvalid  out  1  one-cycle completion pulse (loads and stores)
- d_rdata  out  DATA_W  load data; 0 for stores
- mem_en  out  1  memory access strobe, one cycle per transaction
- mem_we  out  1  memory write
- mem_addr  out  ADDR_W  byte address, passed through unmodified
- mem_wdata  out  DATA_W  write data
- mem_be  out  DATA_W/8  byte enables
- mem_rdata  in  DATA_W  valid in cycle E+MEM_LAT, where E is the mem_en cycle
- busy  out  1  high in every state other than IDLE

## Operation
- States:
  - IDLE: arbitrate. If any request is present, latch the winner and go to ISSUE.
  - ISSUE: mem_en=1, winner's gnt=1. Go to WAIT with lat_cnt=MEM_LAT-1.
  - WAIT: decrement lat_cnt. When lat_cnt=0, capture mem_rdata into the response register and go to RESP.
  - RESP: winner's rvalid=1. Arbitrate exactly as in IDLE: go to ISSUE if a request is present, otherwise go to IDLE.
- Arbitration: data wins over fetch, except when starve_cnt==STARVE_MAX and if_req=1; then fetch wins.
- starve_cnt, width clog2(STARVE_MAX+1):
  - increments, saturating at STARVE_MAX, on a data win while if_req=1
  - clears on a fetch win
  - clears in any arbitration cycle where if_req=0
- A fetch transaction is driven as mem_we=0, mem_be all ones, mem_wdata=0.
- A store transaction returns d_rdata=0 and still pulses d_rvalid.
- Only one transaction is outstanding at a time. The non-winning request stays pending and is not acknowledged.
- Only one gnt and only one rvalid are high in any cycle.
- A requester that drops req before it is latched is ignored. Once a request is latched, the transaction completes regardless of req.
- mem_* outputs are registered and are 0 whenever mem_en=0.

## Timing
- Reset (rst=0 at a clock edge):
  - state=IDLE, starve_cnt=0, response register=0
  - all outputs 0
- Reset asserted mid-transaction aborts it: no gnt or rvalid follows, and the response is discarded. The first arbitration after release happens in the cycle following the first edge with rst=1.
- Request seen in IDLE at cycle T:
  - gnt and mem_en in cycle T+1 (=E)
  - rvalid in cycle E+MEM_LAT+1
  - for MEM_LAT=1: grant at T+1, response at T+3
- Back-to-back: a request present during RESP issues in the next cycle. Sustained throughput is one transaction per MEM_LAT+2 cycles.
- rdata is held stable from the rvalid cycle until the next capture.
- Requests arriving in ISSUE or WAIT are not sampled until RESP.

## Test plan
- Single fetch, MEM_LAT=1:
  - stimulus: if_req=1 at cycle 0, if_addr=0x100, memory returns 0xDEADBEEF
  - required: if_gnt and mem_en with mem_addr=0x100 in cycle 1; if_rvalid with if_rdata=0xDEADBEEF in cycle 3; busy high in cycles 1–3
- Simultaneous requests:
  - stimulus: if_req and d_req (load, 0x200) both high at cycle 0
  - required: d_gnt in cycle 1; d_rvalid in cycle 3; if_gnt in cycle 4 (issued from RESP); if_rvalid in cycle 6
- Starvation, STARVE_MAX=4:
  - stimulus: d_req and if_req both held high continuously
  - required: grant order is D,D,D,D,F,D,D,D,D,F; starve_cnt clears after each F
- Store:
  - stimulus: d_we=1, d_addr=0x40, d_wdata=0x12345678, d_be=4'b0011
  - required: mem_we=1 with those values for exactly one cycle; d_rvalid pulses with d_rdata=0; no if_* activity
- MEM_LAT=3:
  - stimulus: a single load
  - required: gnt at T+1, rvalid at T+5; mem_rdata is sampled only in cycle E+3
- Reset mid-transaction:
  - stimulus: rst=0 during WAIT
  - required: outputs are 0 from the next cycle; no rvalid ever appears for the aborted request; a request held through reset is granted one cycle after reset release
